ycr_mem_responder: RTL and testbench
====================================

Name: ycr_mem_responder

Overview:
- Target-side endpoint of the core memory request interface (req/cmd/width/addr/bl/wdata in; req_ack/rdata/resp out).
- Sits behind the per-target router output and serves requests from a single-port synchronous SRAM, such as a TCM macro.
- Handles single and burst transfers, generates byte masks, and flags range and alignment errors.
- The last beat of every transfer is signalled with RDY_LOK.

Parameters:
- AW, 32: request address width (YCR_IMEM_AWIDTH)
- DW, 32: data width (YCR_IMEM_DWIDTH); fixed 32 for mask generation
- BW, 10: burst length field width (YCR_IMEM_BSIZE)
- MEM_AW, 9: SRAM word-address width; capacity 4*2^MEM_AW bytes

Ports:
- clk  in  1  clock; all logic rising-edge
- rst_n  in  1  reset, synchronous, active-low
- core_req  in  1  request valid; held until req_ack
- core_cmd  in  1  0=read, 1=write
- core_width  in  2  00 byte, 01 half, 10 word, 11 illegal
- core_addr  in  AW  byte address
- core_bl  in  BW  burst length in beats; 0 treated as 1
- core_wdata  in  DW  write data for the current beat
- core_req_ack  out  1  command/beat accepted
- core_rdata  out  DW  read data; zero when resp != RDY_OK/RDY_LOK for a read
- core_resp  out  2  00 NOTRDY, 01 RDY_OK, 10 RDY_ER, 11 RDY_LOK
- mem_cs  out  1  SRAM select
- mem_we  out  1  SRAM write enable
- mem_wmask  out  4  SRAM byte write mask
- mem_addr  out  MEM_AW  SRAM word address
- mem_wdata  out  DW  SRAM write data
- mem_rdata  in  DW  SRAM read data, valid 1 cycle after a read select

Behaviour:
- Reset (rst_n=0 at a clock edge): FSM=IDLE; beat counter=0; core_resp=NOTRDY; core_req_ack=0; core_rdata=0; mem_cs=0; mem_we=0. Applies mid-burst: the transfer is abandoned with no further response.
- FSM states: IDLE, RD, WR, ERR, WRESP.
- Error check, evaluated in IDLE on core_req. Error if any of:
  - addr[AW-1:MEM_AW+2] != 0;
  - width=11;
  - half with addr[0]=1;
  - word with addr[1:0] != 0;
  - effective bl > 1 with width != word.
- IDLE, core_req and error:
  - req_ack=1 for 1 cycle; no SRAM access; go to ERR.
  - ERR drives resp=RDY_ER for exactly 1 cycle, then returns to IDLE.
  - The initiator drops req after RDY_ER.
- IDLE, core_req, read, no error:
  - req_ack=1 at cycle T; beat 0 SRAM read issued at T (mem_cs=1, mem_we=0); latch word address and remaining = bl_eff.
  - In RD, beat k is read at T+k and returned at T+1+k with resp=RDY_OK; the final beat carries RDY_LOK.
  - Read beats are back-to-back with no gaps. core_rdata = mem_rdata (full word, unshifted) during response cycles.
  - Returns to IDLE the cycle after RDY_LOK; req_ack stays 0 for the rest of the burst.
- IDLE, core_req, write, no error:
  - Each beat is accepted with req_ack=1 in the cycle it is written (mem_cs=1, mem_we=1, mem_wdata=core_wdata, mem_addr=current word address).
  - Beat 0 is written in IDLE; further beats in WR, one per cycle while core_req=1.
  - If core_req=0 in WR, the responder waits with req_ack=0, no write, and the counter held.
  - After the last beat, go to WRESP: resp=RDY_LOK for 1 cycle, then IDLE.
  - Intermediate write beats give resp=NOTRDY.
- Mask: byte → 1<<addr[1:0]; half → 0011 or 1100 by addr[1]; word → 1111. Reads drive mem_wmask=0.
- Address: word address increments by 1 per beat and wraps modulo 2^MEM_AW. Range is checked on the start address only.
- No overlap: a new request is accepted only in IDLE, so the minimum gap is 1 idle cycle after RDY_LOK or RDY_ER.
- Outputs core_resp and core_rdata change only on clk edges; core_req_ack and mem_* are combinational from state and inputs.

Test Plan:
- Single word read at addr 0x10, preloaded 0xDEADBEEF → req_ack at T, mem_addr=4; T+1 resp=11 with rdata=0xDEADBEEF; IDLE at T+2.
- Read burst bl=4 at 0x20, data 1..4 → resp 01,01,01,11 on T+1..T+4 with rdata 1,2,3,4; single req_ack.
- Byte write 0xAB at 0x103 → mem_wmask=1000, mem_addr=0x40 in the ack cycle; next cycle resp=11. Half write at 0x102 → mask=1100.
- Write burst bl=3 at 0x0 with core_req dropped for 2 cycles after beat 1 → exactly 3 acks and 3 writes at addresses 0,1,2; RDY_LOK once, 1 cycle after the third ack.
- Errors: word read at 0x2, read at 0x800 (MEM_AW=9), byte burst bl=2 → each case gives 1 ack, mem_cs never set, resp=10 for one cycle, then IDLE.
- rst_n=0 during beat 2 of a bl=8 read → next cycle resp=00, mem_cs=0, FSM IDLE; a fresh request afterwards is served correctly.

Source files
------------

// File: rtl/ycr_mem_responder_if.sv
// Core memory request/response bus between an initiator and the memory responder.
interface ycr_mem_responder_if #(
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int BW = 10
) ();
  logic          core_req;
  logic          core_cmd;
  logic [1:0]    core_width;
  logic [AW-1:0] core_addr;
  logic [BW-1:0] core_bl;
  logic [DW-1:0] core_wdata;
  logic          core_req_ack;
  logic [DW-1:0] core_rdata;
  logic [1:0]    core_resp;

  modport master (
    output core_req, core_cmd, core_width, core_addr, core_bl, core_wdata,
    input  core_req_ack, core_rdata, core_resp
  );

  modport slave (
    input  core_req, core_cmd, core_width, core_addr, core_bl, core_wdata,
    output core_req_ack, core_rdata, core_resp
  );
endinterface

// File: rtl/ycr_mem_responder.sv
// Target-side memory responder: serves single/burst core requests from a
// single-port synchronous SRAM, with byte masks and range/alignment errors.
module ycr_mem_responder #(
  parameter int AW     = 32,
  parameter int DW     = 32,
  parameter int BW     = 10,
  parameter int MEM_AW = 9
) (
  input  logic              clk,
  input  logic              rst_n,
  ycr_mem_responder_if.slave bus,
  output logic              mem_cs,
  output logic              mem_we,
  output logic [3:0]        mem_wmask,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [DW-1:0]     mem_wdata,
  input  logic [DW-1:0]     mem_rdata
);

  // state | meaning
  // IDLE  | waiting for a request; beat 0 is served here
  // RD    | issuing remaining read beats / returning read data
  // WR    | accepting remaining write beats while core_req is high
  // ERR   | RDY_ER response cycle
  // WRESP | RDY_LOK response cycle closing a write
  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] RD    = 3'd1;
  localparam logic [2:0] WR    = 3'd2;
  localparam logic [2:0] ERR   = 3'd3;
  localparam logic [2:0] WRESP = 3'd4;

  localparam logic [1:0] NOTRDY  = 2'b00;
  localparam logic [1:0] RDY_OK  = 2'b01;
  localparam logic [1:0] RDY_ER  = 2'b10;
  localparam logic [1:0] RDY_LOK = 2'b11;

  logic [2:0]        state_q, state_d;
  logic [MEM_AW-1:0] addr_q, addr_d;
  logic [BW-1:0]     cnt_q, cnt_d;
  logic [3:0]        mask_q, mask_d;
  logic [1:0]        resp_q, resp_d;
  logic              rd_q, rd_d;

  logic [MEM_AW-1:0] start_waddr;
  logic [BW-1:0]     bl_eff;
  logic              req_err;
  logic [3:0]        req_mask;
  logic              ack, cs, we;
  logic [3:0]        wmask;

  assign start_waddr = bus.core_addr[MEM_AW+1:2];
  assign bl_eff      = (bus.core_bl == '0) ? BW'(1) : bus.core_bl;

  always_comb begin
    req_err  = (bus.core_addr[AW-1:MEM_AW+2] != '0);
    req_mask = 4'b0000;
    case (bus.core_width)
      2'b00: req_mask = 4'b0001 << bus.core_addr[1:0];
      2'b01: begin
        req_mask = bus.core_addr[1] ? 4'b1100 : 4'b0011;
        req_err  = req_err | bus.core_addr[0];
      end
      2'b10: begin
        req_mask = 4'b1111;
        req_err  = req_err | (bus.core_addr[1:0] != 2'b00);
      end
      default: req_err = 1'b1;
    endcase
    if (bl_eff != BW'(1) && bus.core_width != 2'b10) req_err = 1'b1;
  end

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    cnt_d    = cnt_q;
    mask_d   = mask_q;
    resp_d   = NOTRDY;
    rd_d     = 1'b0;
    ack      = 1'b0;
    cs       = 1'b0;
    we       = 1'b0;
    wmask    = 4'b0000;
    mem_addr = addr_q;
    case (state_q)
      IDLE: begin
        mem_addr = start_waddr;
        if (bus.core_req) begin
          ack = 1'b1;
          if (req_err) begin
            state_d = ERR;
            resp_d  = RDY_ER;
          end else begin
            cs     = 1'b1;
            addr_d = start_waddr + MEM_AW'(1);
            cnt_d  = bl_eff - BW'(1);
            if (!bus.core_cmd) begin
              state_d = RD;
              rd_d    = 1'b1;
              resp_d  = (bl_eff == BW'(1)) ? RDY_LOK : RDY_OK;
            end else begin
              we      = 1'b1;
              wmask   = req_mask;
              mask_d  = req_mask;
              state_d = (bl_eff == BW'(1)) ? WRESP : WR;
              resp_d  = (bl_eff == BW'(1)) ? RDY_LOK : NOTRDY;
            end
          end
        end
      end
      RD: begin
        if (cnt_q != '0) begin
          cs     = 1'b1;
          addr_d = addr_q + MEM_AW'(1);
          cnt_d  = cnt_q - BW'(1);
          rd_d   = 1'b1;
          resp_d = (cnt_q == BW'(1)) ? RDY_LOK : RDY_OK;
        end else begin
          state_d = IDLE;
        end
      end
      WR: begin
        if (bus.core_req) begin
          ack    = 1'b1;
          cs     = 1'b1;
          we     = 1'b1;
          wmask  = mask_q;
          addr_d = addr_q + MEM_AW'(1);
          cnt_d  = cnt_q - BW'(1);
          if (cnt_q == BW'(1)) begin
            state_d = WRESP;
            resp_d  = RDY_LOK;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Nothing reaches the bus or the SRAM while reset is asserted.
  assign bus.core_req_ack = ack & rst_n;
  assign mem_cs           = cs & rst_n;
  assign mem_we           = we & rst_n;
  assign mem_wmask        = rst_n ? wmask : 4'b0000;
  assign mem_wdata        = bus.core_wdata;
  assign bus.core_resp    = resp_q;
  // mem_rdata is the SRAM output register, so this still moves only on clk edges.
  assign bus.core_rdata   = rd_q ? mem_rdata : '0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      cnt_q   <= '0;
      mask_q  <= 4'b0000;
      resp_q  <= NOTRDY;
      rd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      mask_q  <= mask_d;
      resp_q  <= resp_d;
      rd_q    <= rd_d;
    end
  end

endmodule

// File: tb/tb_ycr_mem_responder.sv
// Directed bench for ycr_mem_responder with a behavioural single-port SRAM.
module tb_ycr_mem_responder;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_cs, mem_we;
  logic [3:0]  mem_wmask;
  logic [8:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  logic [31:0] sram [512];
  int n_cmp = 0;
  int n_err = 0;
  int n_ack = 0, n_wr = 0, n_cs = 0, n_lok = 0;

  ycr_mem_responder_if #(.AW(32), .DW(32), .BW(10)) bus ();

  ycr_mem_responder #(.AW(32), .DW(32), .BW(10), .MEM_AW(9)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .mem_cs    (mem_cs),
    .mem_we    (mem_we),
    .mem_wmask (mem_wmask),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_cs) begin
      if (mem_we) begin
        for (int b = 0; b < 4; b++)
          if (mem_wmask[b]) sram[mem_addr][8*b +: 8] = mem_wdata[8*b +: 8];
      end else begin
        mem_rdata <= sram[mem_addr];
      end
    end
  end

  always @(negedge clk) begin
    if (bus.core_req_ack) n_ack++;
    if (mem_cs) n_cs++;
    if (mem_cs && mem_we) n_wr++;
    if (bus.core_resp == 2'b11) n_lok++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic req, input logic cmd, input logic [1:0] w,
                       input logic [31:0] a, input logic [9:0] bl, input logic [31:0] wd);
    bus.core_req   = req;
    bus.core_cmd   = cmd;
    bus.core_width = w;
    bus.core_addr  = a;
    bus.core_bl    = bl;
    bus.core_wdata = wd;
    #1;
  endtask

  typedef struct { logic cmd; logic [1:0] w; logic [31:0] a; logic [9:0] bl; } err_vec_t;
  err_vec_t errs [3];
  int a0, c0, w0, l0;

  initial begin
    for (int i = 0; i < 512; i++) sram[i] = 32'h0;
    sram[4]   = 32'hDEADBEEF;
    sram[8]   = 32'd1; sram[9] = 32'd2; sram[10] = 32'd3; sram[11] = 32'd4;
    sram[12]  = 32'd5; sram[13] = 32'd6; sram[14] = 32'd7; sram[15] = 32'd8;
    sram[64]  = 32'h11223344;
    sram[511] = 32'hCAFE0001;
    sram[0]   = 32'hCAFE0002;
    errs[0] = '{1'b0, 2'b10, 32'h2,   10'd1};
    errs[1] = '{1'b0, 2'b10, 32'h800, 10'd1};
    errs[2] = '{1'b0, 2'b00, 32'h0,   10'd2};

    rst_n = 1'b0;
    drive(1'b0, 1'b0, 2'b10, 32'h0, 10'd1, 32'h0);
    repeat (3) cyc();
    chk("rst_resp", bus.core_resp, 2'b00);
    chk("rst_rdata", bus.core_rdata, 32'h0);
    chk("rst_ack", bus.core_req_ack, 1'b0);
    chk("rst_cs", mem_cs, 1'b0);
    rst_n = 1'b1;
    cyc();

    // single word read
    drive(1'b1, 1'b0, 2'b10, 32'h10, 10'd1, 32'h0);
    chk("rd1_ack", bus.core_req_ack, 1'b1);
    chk("rd1_cs", {mem_cs, mem_we}, 2'b10);
    chk("rd1_addr", mem_addr, 9'd4);
    chk("rd1_mask", mem_wmask, 4'b0000);
    cyc();
    drive(1'b0, 1'b0, 2'b10, 32'h0, 10'd1, 32'h0);
    chk("rd1_resp", bus.core_resp, 2'b11);
    chk("rd1_data", bus.core_rdata, 32'hDEADBEEF);
    chk("rd1_ack_off", bus.core_req_ack, 1'b0);
    cyc();
    chk("rd1_idle", dut.state_q, 3'd0);
    chk("rd1_resp_end", bus.core_resp, 2'b00);

    // read burst of 4 at 0x20
    a0 = n_ack;
    drive(1'b1, 1'b0, 2'b10, 32'h20, 10'd4, 32'h0);
    chk("rb_addr0", mem_addr, 9'd8);
    cyc();
    drive(1'b0, 1'b0, 2'b10, 32'h0, 10'd1, 32'h0);
    for (int k = 0; k < 4; k++) begin
      chk("rb_resp", bus.core_resp, (k < 3) ? 2'b01 : 2'b11);
      chk("rb_data", bus.core_rdata, 32'(k + 1));
      chk("rb_cs", mem_cs, (k < 3) ? 1'b1 : 1'b0);
      if (k < 3) chk("rb_addr", mem_addr, 9'(9 + k));
      cyc();
    end
    chk("rb_idle", dut.state_q, 3'd0);
    chk("rb_acks", n_ack - a0, 1);

    // byte write 0xAB at 0x103, then read back
    drive(1'b1, 1'b1, 2'b00, 32'h103, 10'd1, 32'hAB000000);
    chk("bw_mask", mem_wmask, 4'b1000);
    chk("bw_addr", mem_addr, 9'h40);
    chk("bw_we", {bus.core_req_ack, mem_cs, mem_we}, 3'b111);
    cyc();
    drive(1'b0, 1'b0, 2'b10, 32'h0, 10'd1, 32'h0);
    chk("bw_resp", bus.core_resp, 2'b11);
    cyc();
    drive(1'b1, 1'b1, 2'b01, 32'h102, 10'd1, 32'hCDEF0000);
    chk("hw_mask", mem_wmask, 4'b1100);
    cyc();
    drive(1'b0, 1'b0, 2'b10, 32'h0, 10'd1, 32'h0);
    chk("hw_resp", bus.core_resp, 2'b11);
    cyc();
    drive(1'b1, 1'b0, 2'b00, 32'h101, 10'd1, 32'h0);
    cyc();
    drive(1'b0, 1'b0, 2'b10, 32'h0, 10'd1, 32'h0);
    chk("byte_rd_data", bus.core_rdata, 32'hCDEF3344);
    cyc();

    // write burst of 3 at 0x0 with a 2-cycle stall after beat 1
    a0 = n_ack; w0 = n_wr; l0 = n_lok;
    drive(1'b1, 1'b1, 2'b10, 32'h0, 10'd3, 32'hA0A0A0A0);
    chk("wb_addr0", mem_addr, 9'd0);
    cyc();
    drive(1'b1, 1'b1, 2'b10, 32'h0, 10'd3, 32'hA1A1A1A1);
    chk("wb_ack1", bus.core_req_ack, 1'b1);
    chk("wb_addr1", mem_addr, 9'd1);
    chk("wb_resp1", bus.core_resp, 2'b00);
    cyc();
    for (int s = 0; s < 2; s++) begin
      drive(1'b0, 1'b1, 2'b10, 32'h0, 10'd3, 32'h0);
      chk("wb_stall", {bus.core_req_ack, mem_cs, bus.core_resp}, 4'b0000);
      cyc();
    end
    drive(1'b1, 1'b1, 2'b10, 32'h0, 10'd3, 32'hA2A2A2A2);
    chk("wb_addr2", mem_addr, 9'd2);
    chk("wb_ack2", bus.core_req_ack, 1'b1);
    cyc();
    drive(1'b0, 1'b0, 2'b10, 32'h0, 10'd1, 32'h0);
    chk("wb_lok", bus.core_resp, 2'b11);
    cyc();
    chk("wb_idle", dut.state_q, 3'd0);
    chk("wb_acks", n_ack - a0, 3);
    chk("wb_writes", n_wr - w0, 3);
    chk("wb_lok_cnt", n_lok - l0, 1);
    chk("wb_mem0", sram[0], 32'hA0A0A0A0);
    chk("wb_mem1", sram[1], 32'hA1A1A1A1);
    chk("wb_mem2", sram[2], 32'hA2A2A2A2);

    // error cases
    for (int e = 0; e < 3; e++) begin
      a0 = n_ack; c0 = n_cs;
      drive(1'b1, errs[e].cmd, errs[e].w, errs[e].a, errs[e].bl, 32'h0);
      chk("err_ack", bus.core_req_ack, 1'b1);
      cyc();
      drive(1'b0, 1'b0, 2'b10, 32'h0, 10'd1, 32'h0);
      chk("err_resp", bus.core_resp, 2'b10);
      chk("err_rdata", bus.core_rdata, 32'h0);
      cyc();
      chk("err_resp_end", bus.core_resp, 2'b00);
      chk("err_idle", dut.state_q, 3'd0);
      chk("err_acks", n_ack - a0, 1);
      chk("err_cs", n_cs - c0, 0);
    end

    // word address wraps at the top of the SRAM
    drive(1'b1, 1'b0, 2'b10, 32'h7FC, 10'd2, 32'h0);
    chk("wrap_addr0", mem_addr, 9'd511);
    cyc();
    drive(1'b0, 1'b0, 2'b10, 32'h0, 10'd1, 32'h0);
    chk("wrap_addr1", mem_addr, 9'd0);
    chk("wrap_data0", bus.core_rdata, 32'hCAFE0001);
    cyc();
    chk("wrap_data1", bus.core_rdata, 32'hA0A0A0A0);
    chk("wrap_lok", bus.core_resp, 2'b11);
    cyc();

    // reset in the middle of an 8-beat read
    drive(1'b1, 1'b0, 2'b10, 32'h20, 10'd8, 32'h0);
    cyc();
    drive(1'b0, 1'b0, 2'b10, 32'h0, 10'd1, 32'h0);
    cyc();
    chk("mid_beat2_addr", mem_addr, 9'd10);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_cs", mem_cs, 1'b0);
    cyc();
    rst_n = 1'b1;
    #1;
    chk("mid_resp", bus.core_resp, 2'b00);
    chk("mid_cs", mem_cs, 1'b0);
    chk("mid_idle", dut.state_q, 3'd0);
    chk("mid_rdata", bus.core_rdata, 32'h0);
    cyc();
    drive(1'b1, 1'b0, 2'b10, 32'h10, 10'd0, 32'h0);
    chk("post_ack", bus.core_req_ack, 1'b1);
    cyc();
    drive(1'b0, 1'b0, 2'b10, 32'h0, 10'd1, 32'h0);
    chk("post_resp", bus.core_resp, 2'b11);
    chk("post_data", bus.core_rdata, 32'hDEADBEEF);
    cyc();
    chk("post_idle", dut.state_q, 3'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
